// File: rtl/cpu_control_unit.sv
// Moore sequencer for dataPath: fetch T0-T3, opcode-dependent execute E0-E5, HLT.
// Define CU_ILLEGAL_TRAP_EN to trap undefined opcodes into HLT with a sticky illegal flag.
module cpu_control_unit #(
  parameter logic [3:0] ADD_OP = 4'd0,
  parameter logic [3:0] SUB_OP = 4'd1,
  parameter logic [3:0] SHR_OP = 4'd2,
  parameter logic [3:0] SHL_OP = 4'd3,
  parameter logic [3:0] ROR_OP = 4'd4,
  parameter logic [3:0] ROL_OP = 4'd5,
  parameter logic [3:0] AND_OP = 4'd6,
  parameter logic [3:0] OR_OP  = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IRval,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        BAout,
  output logic        MARin,
  output logic        MDRin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowin,
  output logic        OutPortin,
  output logic        HIin,
  output logic        LOin,
  output logic        Zhighin,
  output logic        Zhighout,
  output logic        InPortin,
  output logic        Rin,
  output logic        Rout,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        IncPc,
  output logic        read,
  output logic        write,
  output logic [1:0]  mdr_read,
  output logic [3:0]  control,
  output logic        run,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_E0  = 4'd5, S_E1 = 4'd6, S_E2 = 4'd7, S_E3 = 4'd8, S_E4 = 4'd9,
    S_E5  = 4'd10, S_HLT = 4'd11
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001, OP_OR   = 5'b01010, OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100, OP_ORI  = 5'b01101, OP_JR   = 5'b10011;
  localparam logic [4:0] OP_IN   = 5'b10101, OP_OUT  = 5'b10110, OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000, OP_NOP  = 5'b11001, OP_HALT = 5'b11010;

  state_t     state_q;
  logic [4:0] opcode;
  logic [2:0] seq_len;
  logic       is_rr, is_imm, is_mem, is_halt, is_legal;
  logic [3:0] alu_ctl;
  logic       unused_ir;

  assign opcode    = IRval[31:27];
  assign unused_ir = ^IRval[26:0];
  assign dbg_state = state_q;

  // seq_len is the number of execute steps; 0 means straight back to fetch.
  always_comb begin
    seq_len  = 3'd0;
    is_rr    = 1'b0;
    is_imm   = 1'b0;
    is_mem   = 1'b0;
    is_halt  = 1'b0;
    is_legal = 1'b1;
    alu_ctl  = ADD_OP;
    case (opcode)
      OP_LD:   begin seq_len = 3'd6; is_mem = 1'b1; end
      OP_LDI:  begin seq_len = 3'd3; is_mem = 1'b1; end
      OP_ST:   begin seq_len = 3'd5; is_mem = 1'b1; end
      OP_ADD:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = ADD_OP; end
      OP_SUB:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = SUB_OP; end
      OP_SHR:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = SHR_OP; end
      OP_SHL:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = SHL_OP; end
      OP_ROR:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = ROR_OP; end
      OP_ROL:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = ROL_OP; end
      OP_AND:  begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = AND_OP; end
      OP_OR:   begin seq_len = 3'd3; is_rr = 1'b1; alu_ctl = OR_OP; end
      OP_ADDI: begin seq_len = 3'd3; is_imm = 1'b1; alu_ctl = ADD_OP; end
      OP_ANDI: begin seq_len = 3'd3; is_imm = 1'b1; alu_ctl = AND_OP; end
      OP_ORI:  begin seq_len = 3'd3; is_imm = 1'b1; alu_ctl = OR_OP; end
      OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: seq_len = 3'd1;
      OP_NOP:  seq_len = 3'd0;
      OP_HALT: is_halt = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
`ifdef CU_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RST: state_q <= S_T0;
        S_T0:  state_q <= S_T1;
        S_T1:  state_q <= S_T2;
        S_T2:  state_q <= S_T3;
        S_T3: begin
          if (is_halt) begin
            state_q <= S_HLT;
          end else if (!is_legal) begin
`ifdef CU_ILLEGAL_TRAP_EN
            state_q   <= S_HLT;
            illegal_q <= 1'b1;
`else
            state_q <= S_T0;
`endif
          end else if (seq_len == 3'd0) begin
            state_q <= S_T0;
          end else begin
            state_q <= S_E0;
          end
        end
        S_E0:  state_q <= (seq_len > 3'd1) ? S_E1 : S_T0;
        S_E1:  state_q <= (seq_len > 3'd2) ? S_E2 : S_T0;
        S_E2:  state_q <= (seq_len > 3'd3) ? S_E3 : S_T0;
        S_E3:  state_q <= (seq_len > 3'd4) ? S_E4 : S_T0;
        S_E4:  state_q <= (seq_len > 3'd5) ? S_E5 : S_T0;
        S_E5:  state_q <= S_T0;
        S_HLT: state_q <= S_HLT;
        default: state_q <= S_RST;
      endcase
    end
  end

  assign HIin     = 1'b0;
  assign LOin     = 1'b0;
  assign Zhighin  = 1'b0;
  assign Zhighout = 1'b0;
  assign InPortin = 1'b0;

  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; PCin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowin = 1'b0; OutPortin = 1'b0;
    Rin = 1'b0; Rout = 1'b0; GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
    IncPc = 1'b0; read = 1'b0; write = 1'b0;
    mdr_read = 2'b00;
    control  = ADD_OP;
    run      = (state_q != S_RST) && (state_q != S_HLT);
    case (state_q)
      S_RST: control = 4'd0;
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zin = 1'b1; Zlowin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; end
      S_T2: begin read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1; end
      S_T3: begin MDRout = 1'b1; IRin = 1'b1; end
      S_E0: begin
        if (is_rr || is_imm) begin
          GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_mem) begin
          // BAout makes R0 contribute 0 to the effective address.
          GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else begin
          case (opcode)
            OP_JR:   begin GRA = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            OP_IN:   begin InPortout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            OP_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
            OP_MFHI: begin HIout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            OP_MFLO: begin LOout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
            default: ;
          endcase
        end
      end
      S_E1: begin
        if (is_rr) begin
          GRC = 1'b1; Rout = 1'b1; Zin = 1'b1; Zlowin = 1'b1; control = alu_ctl;
        end else if (is_imm) begin
          Cout = 1'b1; Zin = 1'b1; Zlowin = 1'b1; control = alu_ctl;
        end else if (is_mem) begin
          Cout = 1'b1; Zin = 1'b1; Zlowin = 1'b1;
        end
      end
      S_E2: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_rr || is_imm || opcode == OP_LDI) begin
          Zlowout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end
      end
      S_E3: begin
        if (opcode == OP_LD) begin
          read = 1'b1;
        end else if (opcode == OP_ST) begin
          GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end
      end
      S_E4: begin
        if (opcode == OP_LD) begin
          read = 1'b1; mdr_read = 2'b01; MDRin = 1'b1;
        end else if (opcode == OP_ST) begin
          write = 1'b1;
        end
      end
      S_E5: begin
        if (opcode == OP_LD) begin
          MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: every cycle's full strobe vector is compared
// against hand-written expected sequences for each instruction class.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IRval;
  logic PCout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
  logic MARin, MDRin, PCin, IRin, Yin, Zin, Zlowin, OutPortin;
  logic HIin, LOin, Zhighin, Zhighout, InPortin;
  logic Rin, Rout, GRA, GRB, GRC, IncPc, read, write;
  logic [1:0] mdr_read;
  logic [3:0] control;
  logic       run;
  logic [3:0] dbg_state_unused;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_control_unit dut (
    .clk(clk), .reset(reset), .IRval(IRval),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .MARin(MARin), .MDRin(MDRin),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowin(Zlowin), .OutPortin(OutPortin),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zhighout(Zhighout), .InPortin(InPortin),
    .Rin(Rin), .Rout(Rout), .GRA(GRA), .GRB(GRB), .GRC(GRC), .IncPc(IncPc),
    .read(read), .write(write), .mdr_read(mdr_read), .control(control), .run(run),
`ifdef CU_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .dbg_state(dbg_state_unused)
  );

  localparam logic [28:0] S_PCOUT = 29'd1 << 28, S_ZLOWOUT = 29'd1 << 27, S_MDROUT = 29'd1 << 26;
  localparam logic [28:0] S_HIOUT = 29'd1 << 25, S_LOOUT = 29'd1 << 24, S_INPORTOUT = 29'd1 << 23;
  localparam logic [28:0] S_COUT = 29'd1 << 22, S_BAOUT = 29'd1 << 21, S_MARIN = 29'd1 << 20;
  localparam logic [28:0] S_MDRIN = 29'd1 << 19, S_PCIN = 29'd1 << 18, S_IRIN = 29'd1 << 17;
  localparam logic [28:0] S_YIN = 29'd1 << 16, S_ZIN = 29'd1 << 15, S_ZLOWIN = 29'd1 << 14;
  localparam logic [28:0] S_OUTPORTIN = 29'd1 << 13, S_RIN = 29'd1 << 7, S_ROUT = 29'd1 << 6;
  localparam logic [28:0] S_GRA = 29'd1 << 5, S_GRB = 29'd1 << 4, S_GRC = 29'd1 << 3;
  localparam logic [28:0] S_INCPC = 29'd1 << 2, S_READ = 29'd1 << 1, S_WRITE = 29'd1;

  logic [28:0] strobes;
  logic [35:0] obs;
  assign strobes = {PCout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
                    MARin, MDRin, PCin, IRin, Yin, Zin, Zlowin, OutPortin,
                    HIin, LOin, Zhighin, Zhighout, InPortin,
                    Rin, Rout, GRA, GRB, GRC, IncPc, read, write};
  assign obs = {strobes, mdr_read, control, run};

  function automatic logic [35:0] vec(input logic [28:0] s, input logic [1:0] m,
                                      input logic [3:0] c, input logic r);
    return {s, m, c, r};
  endfunction

  function automatic logic [35:0] fv(input int k);
    case (k)
      0: return vec(S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1);
      1: return vec(S_ZLOWOUT | S_PCIN | S_READ, 2'b00, 4'd0, 1'b1);
      2: return vec(S_READ | S_MDRIN, 2'b01, 4'd0, 1'b1);
      default: return vec(S_MDROUT | S_IRIN, 2'b00, 4'd0, 1'b1);
    endcase
  endfunction

  task automatic push_fetch();
    exp_q = {};
    for (int k = 0; k < 4; k++) exp_q.push_back(fv(k));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    IRval = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 36'h0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, 36'h0);
      end
    end
`ifdef CU_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_illegal: got %b expected 0", illegal);
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== fv(0)) begin
      errors++;
      $display("FAIL reset_first_t0: got %h expected %h", obs, fv(0));
    end
  endtask

  task automatic test_add();
    push_fetch();
    exp_q.push_back(vec(S_GRB | S_ROUT | S_YIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_GRC | S_ROUT | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_ZLOWOUT | S_GRA | S_RIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(fv(0));
    IRval = 32'h18918000;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL add step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [4:0] ops[7];
    logic [3:0] ctls[7];
    ops  = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010};
    ctls = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    for (int j = 0; j < 7; j++) begin
      push_fetch();
      exp_q.push_back(vec(S_GRB | S_ROUT | S_YIN, 2'b00, 4'd0, 1'b1));
      exp_q.push_back(vec(S_GRC | S_ROUT | S_ZIN | S_ZLOWIN, 2'b00, ctls[j], 1'b1));
      exp_q.push_back(vec(S_ZLOWOUT | S_GRA | S_RIN, 2'b00, 4'd0, 1'b1));
      exp_q.push_back(fv(0));
      IRval = {ops[j], 27'h0123456};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL alu op %b step %0d: got %h expected %h", ops[j], i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_imm();
    logic [4:0] ops[3];
    logic [3:0] ctls[3];
    ops  = '{5'b01011, 5'b01100, 5'b01101};
    ctls = '{4'd0, 4'd6, 4'd7};
    for (int j = 0; j < 3; j++) begin
      push_fetch();
      exp_q.push_back(vec(S_GRB | S_ROUT | S_YIN, 2'b00, 4'd0, 1'b1));
      exp_q.push_back(vec(S_COUT | S_ZIN | S_ZLOWIN, 2'b00, ctls[j], 1'b1));
      exp_q.push_back(vec(S_ZLOWOUT | S_GRA | S_RIN, 2'b00, 4'd0, 1'b1));
      exp_q.push_back(fv(0));
      IRval = {ops[j], 27'h0080055};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL imm op %b step %0d: got %h expected %h", ops[j], i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ld();
    push_fetch();
    exp_q.push_back(vec(S_GRB | S_BAOUT | S_YIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_COUT | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_ZLOWOUT | S_MARIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_READ, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_READ | S_MDRIN, 2'b01, 4'd0, 1'b1));
    exp_q.push_back(vec(S_MDROUT | S_GRA | S_RIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(fv(0));
    IRval = 32'h00900055;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL ld step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_ldi();
    push_fetch();
    exp_q.push_back(vec(S_GRB | S_BAOUT | S_YIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_COUT | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_ZLOWOUT | S_GRA | S_RIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(fv(0));
    IRval = 32'h08900055;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL ldi step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_st();
    int writes = 0;
    int exec_reads = 0;
    push_fetch();
    exp_q.push_back(vec(S_GRB | S_BAOUT | S_YIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_COUT | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_ZLOWOUT | S_MARIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_GRA | S_ROUT | S_MDRIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_WRITE, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(fv(0));
    IRval = 32'h10900055;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (write === 1'b1) writes++;
      if (i >= 4 && i < 9 && read === 1'b1) exec_reads++;
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL st step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
    checks++;
    if (writes != 1) begin
      errors++;
      $display("FAIL st_write_count: got %0d expected 1", writes);
    end
    checks++;
    if (exec_reads != 0) begin
      errors++;
      $display("FAIL st_exec_reads: got %0d expected 0", exec_reads);
    end
  endtask

  task automatic test_single_step();
    logic [4:0]  ops[5];
    logic [28:0] e0s[5];
    ops = '{5'b10011, 5'b10101, 5'b10110, 5'b10111, 5'b11000};
    e0s = '{S_GRA | S_ROUT | S_PCIN, S_INPORTOUT | S_GRA | S_RIN, S_GRA | S_ROUT | S_OUTPORTIN,
            S_HIOUT | S_GRA | S_RIN, S_LOOUT | S_GRA | S_RIN};
    for (int j = 0; j < 5; j++) begin
      push_fetch();
      exp_q.push_back(vec(e0s[j], 2'b00, 4'd0, 1'b1));
      exp_q.push_back(fv(0));
      IRval = {ops[j], 27'h0800000};
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge clk);
        checks++;
        if (obs !== exp_q[i]) begin
          errors++;
          $display("FAIL single op %b step %0d: got %h expected %h", ops[j], i, obs, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_nop();
    push_fetch();
    exp_q.push_back(fv(0));
    IRval = 32'hC8000000;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL nop step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_halt_and_reset();
    push_fetch();
    for (int k = 0; k < 20; k++) exp_q.push_back(36'h0);
    IRval = 32'hD0000000;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL halt step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL halt_reset: got %h expected %h", obs, 36'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== fv(0)) begin
      errors++;
      $display("FAIL halt_restart: got %h expected %h", obs, fv(0));
    end
    push_fetch();
    exp_q.push_back(vec(S_GRB | S_ROUT | S_YIN, 2'b00, 4'd0, 1'b1));
    exp_q.push_back(vec(S_COUT | S_ZIN | S_ZLOWIN, 2'b00, 4'd0, 1'b1));
    IRval = 32'h58800007;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL addi_pre_abort step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 36'h0) begin
      errors++;
      $display("FAIL abort_same_cycle: got %h expected %h", obs, 36'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (Rin !== 1'b0 || obs !== 36'h0) begin
        errors++;
        $display("FAIL abort_no_rin cycle %0d: got %h expected %h", i, obs, 36'h0);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== fv(0)) begin
      errors++;
      $display("FAIL abort_restart: got %h expected %h", obs, fv(0));
    end
  endtask

  task automatic test_undefined();
    push_fetch();
`ifdef CU_ILLEGAL_TRAP_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(36'h0);
`else
    exp_q.push_back(fv(0));
`endif
    IRval = 32'hF8000000;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL undefined step %0d: got %h expected %h", i, obs, exp_q[i]);
      end
    end
`ifdef CU_ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag: got %b expected 1", illegal);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_imm();
    test_ld();
    test_ldi();
    test_st();
    test_single_step();
    test_nop();
    test_halt_and_reset();
    test_undefined();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
